// File: rtl/nios1_mulx_pkg.sv
// Shared types and constants for the sequential MUL/MULX unit.
// Opcodes, FSM states, partial-product helpers and latency bounds.
package nios1_mulx_pkg;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 3;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    FIX   = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam int PP_SHIFT0 = 0;
  localparam int PP_SHIFT1 = 16;
  localparam int PP_SHIFT2 = 16;
  localparam int PP_SHIFT3 = 32;

  // Zero-extended 16-bit half of a word.
  function automatic logic [31:0] pp_half(
    input logic [31:0] x,
    input logic        hi
  );
    return hi ? {16'b0, x[31:16]} : {16'b0, x[15:0]};
  endfunction

  // Partial product placed at its weight in the 64-bit sum.
  function automatic logic [63:0] pp_term(
    input logic [31:0] res,
    input logic [1:0]  idx
  );
    logic [63:0] w;
    w = {32'b0, res};
    unique case (idx)
      2'd0:    return w << PP_SHIFT0;
      2'd1:    return w << PP_SHIFT1;
      2'd2:    return w << PP_SHIFT2;
      default: return w << PP_SHIFT3;
    endcase
  endfunction

endpackage

// File: rtl/nios1_nios2_qsys_0_mulx_tagpipe.sv
// Tag delay line matching the multiply-cell latency.
// Carries a valid bit and partial-product index per issued operand pair.
module nios1_nios2_qsys_0_mulx_tagpipe
  import nios1_mulx_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [1:0] i_idx,
  output logic       o_valid,
  output logic [1:0] o_idx
);

  localparam int DEPTH =
    (MUL_LATENCY < MUL_LAT_MIN) ? MUL_LAT_MIN :
    (MUL_LATENCY > MUL_LAT_MAX) ? MUL_LAT_MAX :
    MUL_LATENCY;

  logic [DEPTH-1:0]      r_v;
  logic [DEPTH-1:0][1:0] r_idx;

  // Shift tags one stage per clock; reset drops all in-flight tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v   <= '0;
      r_idx <= '0;
    end else begin
      r_v[0]   <= i_valid;
      r_idx[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i]   <= r_v[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_v[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/nios1_nios2_qsys_0_mulx_seq.sv
// Sequencer driving an external 32x32->32 multiply cell for MUL/MULX.
// Signed MULX corrections are built only with NIOS1_MULX_SIGNED_EN defined.
module nios1_nios2_qsys_0_mulx_seq
  import nios1_mulx_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] mul_cell_src1,
  output logic [31:0] mul_cell_src2,
  input  logic [31:0] mul_cell_result
);

  state_e      r_state;
  op_e         r_op;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [1:0]  r_cnt;
  logic        r_iss_v;
  logic [1:0]  r_iss_idx;
  logic [31:0] r_cell_a;
  logic [31:0] r_cell_b;
  logic        r_cap_v;
  logic [1:0]  r_cap_idx;
  logic [31:0] r_cap_res;
  logic [63:0] r_acc;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_out_result;

  logic        w_tag_v;
  logic [1:0]  w_tag_idx;
  logic        w_is_mul;
  logic        w_in_mul;
  logic [1:0]  w_nxt;
  logic [63:0] w_acc_nxt;
  logic [31:0] w_corr;

  nios1_nios2_qsys_0_mulx_tagpipe #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_tagpipe (
    .clk    (clk),
    .reset_n(reset_n),
    .i_valid(r_iss_v),
    .i_idx  (r_iss_idx),
    .o_valid(w_tag_v),
    .o_idx  (w_tag_idx)
  );

  assign w_is_mul  = (r_op == OP_MUL);
  assign w_in_mul  = (in_op == 2'd0);
  assign w_nxt     = r_cnt + 2'd1;
  assign w_acc_nxt = r_acc +
    (r_cap_v ? pp_term(r_cap_res, r_cap_idx) : 64'd0);

  // Signed high-word correction applied in FIX.
  always_comb begin
    w_corr = '0;
`ifdef NIOS1_MULX_SIGNED_EN
    if ((r_op == OP_MULXSU || r_op == OP_MULXSS) && r_src1[31])
      w_corr = w_corr + r_src2;
    if (r_op == OP_MULXSS && r_src2[31])
      w_corr = w_corr + r_src1;
`endif
  end

  // Register cell result with its tag so accumulation has a full cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_v   <= 1'b0;
      r_cap_idx <= '0;
      r_cap_res <= '0;
    end else begin
      r_cap_v   <= w_tag_v;
      r_cap_idx <= w_tag_idx;
      r_cap_res <= mul_cell_result;
    end
  end

  // Control FSM with registered handshake, cell operands and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_op         <= OP_MUL;
      r_src1       <= '0;
      r_src2       <= '0;
      r_cnt        <= '0;
      r_iss_v      <= 1'b0;
      r_iss_idx    <= '0;
      r_cell_a     <= '0;
      r_cell_b     <= '0;
      r_acc        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      r_iss_v   <= 1'b0;
      r_iss_idx <= '0;
      r_cell_a  <= '0;
      r_cell_b  <= '0;
      r_acc     <= w_acc_nxt;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op       <= op_e'(in_op);
            r_src1     <= in_src1;
            r_src2     <= in_src2;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_iss_v    <= 1'b1;
            r_iss_idx  <= 2'd0;
            r_cell_a   <= w_in_mul ? in_src1 : pp_half(in_src1, 1'b0);
            r_cell_b   <= w_in_mul ? in_src2 : pp_half(in_src2, 1'b0);
            r_in_ready <= 1'b0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_is_mul || r_cnt == 2'd3) begin
            r_state <= DRAIN;
          end else begin
            r_cnt     <= w_nxt;
            r_iss_v   <= 1'b1;
            r_iss_idx <= w_nxt;
            r_cell_a  <= pp_half(r_src1, w_nxt[0]);
            r_cell_b  <= pp_half(r_src2, w_nxt[1]);
          end
        end
        DRAIN: begin
          if (r_cap_v) begin
            if (w_is_mul) begin
              r_out_valid  <= 1'b1;
              r_out_result <= w_acc_nxt[31:0];
              r_state      <= RESP;
            end else if (r_cap_idx == 2'd3) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          r_out_valid  <= 1'b1;
          r_out_result <= r_acc[63:32] - w_corr;
          r_state      <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_in_ready   <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign mul_cell_src1 = r_cell_a;
  assign mul_cell_src2 = r_cell_b;

endmodule

// File: doc/nios1_nios2_qsys_0_mulx_seq.md
NIOS1_NIOS2_QSYS_0_MULX_SEQ -- requirements
Module: nios1_nios2_qsys_0_mulx_seq

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 1, giving the multiply-cell result latency in clk cycles (legal 1..3).
REQ-002 SHALL have ports: clk in 1, clock; reset_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid in 1, command offered; in_ready out 1, command accepted when both are high at a rising edge.
REQ-004 SHALL have ports: in_op in 2, opcode (0 MUL, 1 MULXUU, 2 MULXSU, 3 MULXSS); in_src1 in 32; in_src2 in 32.
REQ-005 SHALL have ports: out_valid out 1; out_ready in 1; out_result out 32, the low word for MUL and the high word for MULX*.
REQ-006 SHALL have ports: mul_cell_src1 out 32 and mul_cell_src2 out 32, registered operands to the downstream multiply cell.
REQ-007 SHALL have port mul_cell_result in 32, low 32 bits of mul_cell_src1*mul_cell_src2, valid MUL_LATENCY cycles after the operands are driven.
REQ-008 SHALL have one clock (clk) and an asynchronous active-low reset (reset_n).

Function
REQ-009 SHALL use FSM states IDLE, ISSUE, DRAIN, FIX and RESP; in_ready SHALL be 1 only in IDLE.
REQ-010 On accept SHALL latch op and operands and go IDLE->ISSUE.
REQ-011 MUL: ISSUE SHALL last one cycle driving the full operands; DRAIN SHALL capture mul_cell_result unmodified; FIX SHALL be skipped; out_valid SHALL rise 2+MUL_LATENCY cycles after the accept edge.
REQ-012 MULX*: ISSUE SHALL last 4 cycles driving zero-extended 16-bit halves pp0=lo*lo, pp1=hi1*lo2, pp2=lo1*hi2, pp3=hi*hi, one per cycle, back-to-back.
REQ-013 A MUL_LATENCY-deep tag pipe (valid, 2-bit index) SHALL track each partial product; on tag arrival SHALL add result<<(0,16,16,32) into a 64-bit unsigned accumulator cleared at accept.
REQ-014 DRAIN SHALL exit to FIX when the index-3 tag arrives; FIX SHALL take exactly 1 cycle; MULX* out_valid SHALL rise 6+MUL_LATENCY cycles after accept.
REQ-015 FIX SHALL subtract mod 2^32 from the high word: src2 if op is MULXSU/MULXSS and src1[31]=1, and src1 if op is MULXSS and src2[31]=1.
REQ-016 RESP SHALL hold out_valid and out_result stable until out_ready=1, then return to IDLE; in_valid SHALL be ignored outside IDLE.
REQ-017 mul_cell_src1/2 SHALL be driven to 0 in every state other than ISSUE.
REQ-018 out_result SHALL be 0 whenever out_valid=0.

Reset
REQ-019 reset_n low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, out_result=0, mul_cell_src1/2=0, and clear the accumulator and all tag valids.
REQ-020 Reset mid-operation SHALL abandon the command with no output; in-flight cell results arriving after release SHALL be ignored.

Configuration
REQ-021 Macro NIOS1_MULX_SIGNED_EN defined: REQ-015 corrections SHALL be implemented.
REQ-022 Macro NIOS1_MULX_SIGNED_EN undefined: opcodes 2 and 3 SHALL behave exactly as MULXUU, with FIX still taking 1 cycle so latency is unchanged.

Structure
REQ-023 Package nios1_mulx_pkg SHALL hold the opcode enum, the FSM state enum, the partial-product shift constants and the MUL_LATENCY bounds.
REQ-024 The tag delay line SHALL be sub-module nios1_nios2_qsys_0_mulx_tagpipe, parameterised by MUL_LATENCY.
REQ-025 The bench SHALL pair the sequencer with a behavioural multiply-cell model honouring MUL_LATENCY.

Verification
REQ-026 MUL 0x00010003 * 0x00020005, LAT=1 -> out_result 0x000B000F, out_valid at accept+3.
REQ-027 MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE at accept+7; repeat with LAT=3 -> accept+9.
REQ-028 MULXSS 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF with macro defined, 0x00000001 without.
REQ-029 MULXSU 0x80000000 * 0xFFFFFFFF -> 0x80000000 with macro defined.
REQ-030 Hold out_ready low for 5 cycles while in_valid is high -> out_result stays stable, in_ready stays 0 and no second command is accepted; on release the next command is accepted the cycle after IDLE returns.
REQ-031 Assert reset_n low during the ISSUE cycle of pp2 -> all outputs go to 0 immediately; a following MULXUU 3*5 returns 0x00000000 and no stale pulse appears.
